unsigned_divider_seq: RTL and testbench
=======================================

UNSIGNED_DIVIDER_SEQ -- requirements
Module: unsigned_divider_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new division; sampled only in IDLE.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of the operation in progress.
REQ-006 SHALL have port dividend, input, XLEN bits: unsigned dividend, captured on start acceptance.
REQ-007 SHALL have port divisor, input, XLEN bits: unsigned divisor, captured on start acceptance.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking quotient/remainder valid.
REQ-010 SHALL have port quotient, output, XLEN bits: registered unsigned quotient.
REQ-011 SHALL have port remainder, output, XLEN bits: registered unsigned remainder.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; IDLE is the only state accepting start.
REQ-013 SHALL accept start at edge E0 when state=IDLE, start=1 and flush=0, then latch both operands, clear the partial remainder, clear the iteration counter and enter RUN.
REQ-014 SHALL ignore start while in RUN; latched operands stay unchanged.
REQ-015 SHALL perform one restoring step per edge E1..E_XLEN in RUN: shift {partial remainder, dividend} left 1; if shifted remainder >= divisor (unsigned, XLEN+1-bit compare), subtract divisor and set quotient bit 1, else quotient bit 0; MSB first.
REQ-016 SHALL, at edge E_XLEN, register the final quotient/remainder, set done=1 for exactly one cycle, drive busy=0 and return to IDLE.
REQ-017 SHALL give normal latency = XLEN cycles from the acceptance edge to the done edge; a new start may be accepted on the edge right after done.
REQ-018 SHALL handle divisor=0 as a fast path: at E1 quotient = all ones, remainder = dividend, done=1, busy=0, state IDLE (RISC-V DIVU/REMU semantics).
REQ-019 SHALL give dividend < divisor the full XLEN latency, with quotient=0 and remainder=dividend.
REQ-020 SHALL use a counter of width clog2(XLEN)+1 bits with no wrap-around before the terminal count.
REQ-021 SHALL, when flush=1 at any edge in RUN, return to IDLE with busy=0 and no done pulse; quotient/remainder keep their previous values.
REQ-022 SHALL make flush take priority over start in the same cycle; flush in IDLE has no effect.
REQ-023 SHALL hold quotient/remainder stable from the done pulse until the next done pulse.
REQ-024 SHALL drive busy=1 in every cycle that state=RUN, and 0 otherwise.
REQ-025 SHALL never assert done and busy together.

Reset
REQ-026 SHALL, on rst_n=0 and independent of clk, force state=IDLE, busy=0, done=0, quotient=0, remainder=0 and counter=0.
REQ-027 SHALL discard any operation in progress on reset mid-operation, with no done after release.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-029 SHALL be verified by: dividend=100, divisor=7 -> done exactly 64 cycles after acceptance, quotient=14, remainder=2.
REQ-030 SHALL be verified by: dividend=0x1234, divisor=0 -> done 1 cycle after acceptance, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
REQ-031 SHALL be verified by: dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=1 -> quotient=all ones, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-032 SHALL be verified by: start pulsed with new operands at cycle 10 of RUN -> ignored, result matches the first operands; back-to-back start on the edge after done -> accepted.
REQ-033 SHALL be verified by: flush at cycle 30 of RUN -> busy=0 next cycle, no done, outputs unchanged from the prior result.
REQ-034 SHALL be verified by: rst_n pulsed low at cycle 20 of RUN, asynchronous to clk -> all outputs 0 immediately, no done after release.

Source files
------------

// File: rtl/unsigned_divider_seq.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first.
// A zero divisor finishes one edge after acceptance with DIVU/REMU results.
module unsigned_divider_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shl;
  logic            q_bit, accept, div_zero, last;
  logic [XLEN-1:0] rem_nxt, dvd_nxt;

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    shl      = {rem_q, dvd_q[XLEN-1]};
    q_bit    = (shl >= {1'b0, dvs_q});
    rem_nxt  = q_bit ? (shl[XLEN-1:0] - dvs_q) : shl[XLEN-1:0];
    dvd_nxt  = {dvd_q[XLEN-2:0], q_bit};
    accept   = (state == IDLE) && start && !flush;
    div_zero = (dvs_q == '0);
    last     = (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (flush || div_zero || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (state == RUN && !flush) begin
        if (div_zero) begin
          quotient  <= '1;
          remainder <= dvd_q;
          done      <= 1'b1;
        end else begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            quotient  <= dvd_nxt;
            remainder <= rem_nxt;
            done      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_unsigned_divider_seq.sv
// Scoreboard bench for unsigned_divider_seq: expected results are queued at
// acceptance and compared, with latency, when done pulses.
module tb_unsigned_divider_seq;
  localparam int XLEN = 64;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [XLEN-1:0] dividend = '0, divisor = '0;
  logic            busy, done;
  logic [XLEN-1:0] quotient, remainder;

  unsigned_divider_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    int              due;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0, errors = 0, done_cnt = 0;
  logic [XLEN-1:0] last_q = '0, last_r = '0;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      chk("done_with_busy", 64'(busy), 64'd0);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        chk("quotient", quotient, e_mon.q);
        chk("remainder", remainder, e_mon.r);
        chk("latency_cycle", 64'(cyc), 64'(e_mon.due));
        last_q = e_mon.q;
        last_r = e_mon.r;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit track);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 64'(busy), 64'd1);
    if (track) begin
      e.q   = (b == '0) ? '1 : a / b;
      e.r   = (b == '0) ? a : a % b;
      e.due = cyc + ((b == '0) ? 1 : XLEN);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  int d0;

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);

    // Release reset and request on the very first edge afterwards.
    @(negedge clk);
    rst_n = 1'b1;
    issue(64'd100, 64'd7, 1'b1);
    wait_done();
    issue(64'h1234, 64'd0, 1'b1);
    wait_done();
    issue('1, 64'd1, 1'b1);
    wait_done();
    issue(64'd5, 64'd9, 1'b1);
    wait_done();
    for (int i = 0; i < 6; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom} >> (8 * i + 8), 1'b1);
      wait_done();
    end

    // Start during RUN is ignored; restart on the done cycle is accepted.
    issue(64'd1000, 64'd33, 1'b1);
    repeat (10) @(negedge clk);
    dividend = 64'd77;
    divisor  = 64'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_run_busy", 64'(busy), 64'd1);
    wait_done();
    issue(64'hDEAD_BEEF_0000_0001, 64'h1_0000, 1'b1);
    wait_done();

    // Flush at RUN cycle 30: no done, results keep the previous value.
    @(negedge clk);
    issue(64'd999_999, 64'd3, 1'b0);
    repeat (29) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    d0 = done_cnt;
    repeat (80) @(negedge clk);
    chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
    chk("flush_keep_q", quotient, last_q);
    chk("flush_keep_r", remainder, last_r);

    // Flush beats start in IDLE.
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_over_start", 64'(busy), 64'd0);

    // Asynchronous reset at RUN cycle 20.
    issue(64'd123_456_789, 64'd10, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_q", quotient, '0);
    chk("async_rst_r", remainder, '0);
    #3 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (80) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

    issue(64'd4096, 64'd64, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
